// File: rtl/fft_layer_seq.sv
// Issue-side sequencer for one FFT butterfly layer: generates operand/twiddle
// read addresses and delays them through a LAT-deep line to form in-place write-backs.
module fft_layer_seq #(
    parameter int AW      = 7,
    parameter int FPU_LAT = 24,
    parameter int RD_LAT  = 1,
    parameter int MW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    layer,
    input  logic [MW-1:0] mode_i,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-1:0] tw_addr,
    output logic          fpu_en,
    output logic [MW-1:0] fpu_mode,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b
);
    localparam int LAT = RD_LAT + FPU_LAT;
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TOP = ONE << (AW - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [AW-2:0]           k;
    logic [3:0]              layer_r;
    logic [MW-1:0]           mode_r;
    logic [LAT-1:0]          dv;
    logic [LAT-1:0][AW-1:0]  da;
    logic [LAT-1:0][AW-1:0]  db;

    logic                    issue;
    logic                    drain_empty;
    logic [AW-1:0]           kk;
    logic [AW-1:0]           s;
    logic [AW-1:0]           grp;
    logic [AW-1:0]           addr_a;

    always_comb begin
        kk     = {1'b0, k};
        s      = ONE << layer_r;
        grp    = kk >> layer_r;
        addr_a = ((grp << layer_r) << 1) | (kk & (s - ONE));
    end

    assign issue     = (state == ISSUE);
    assign rd_en     = issue & ~hold;
    // addresses are gated to zero outside ISSUE but stay stable across hold
    assign rd_addr_a = issue ? addr_a : '0;
    assign rd_addr_b = issue ? (addr_a | s) : '0;
    assign tw_addr   = issue ? ((TOP >> layer_r) + grp) : '0;

    assign busy      = (state != IDLE);
    assign fpu_en    = busy & ~hold;
    assign fpu_mode  = mode_r;
    assign wr_en     = dv[LAT-1] & ~hold;
    assign wr_addr_a = da[LAT-1];
    assign wr_addr_b = db[LAT-1];

    // The tail entry is written out this cycle, so only the upstream entries
    // decide whether the line is empty after the shift.
    assign drain_empty = ~|dv[LAT-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            layer_r <= '0;
            mode_r  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (32'(layer) < AW) begin
                            layer_r <= layer;
                            mode_r  <= mode_i;
                            k       <= '0;
                            state   <= ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        k <= k + 1'b1;
                        if (&k) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!hold && drain_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv <= '0;
            da <= '0;
            db <= '0;
        end else if (!hold) begin
            dv <= {dv[LAT-2:0], rd_en};
            da <= {da[LAT-2:0], rd_addr_a};
            db <= {db[LAT-2:0], rd_addr_b};
        end
    end
endmodule

// File: tb/tb_fft_layer_seq.sv
// Randomized scoreboard bench for fft_layer_seq: a reference model enumerates the
// butterfly pairs of each layer, a monitor checks reads, writes and control timing.
module tb_fft_layer_seq;
    localparam int AW = 7;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst, start, hold;
    logic [3:0]    layer;
    logic [MW-1:0] mode_i;
    logic          busy, done, err, rd_en, fpu_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [MW-1:0] fpu_mode;

    fft_layer_seq #(.AW(AW), .FPU_LAT(24), .RD_LAT(1), .MW(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .layer(layer), .mode_i(mode_i),
        .hold(hold), .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .fpu_en(fpu_en), .fpu_mode(fpu_mode), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int t;
    } pair_t;

    pair_t rq[$];
    pair_t wq[$];

    int vectors = 0;
    int fails = 0;
    int busy_lo = -1, busy_hi = -2, done_cyc = -1, err_cyc = -1, cur_mode = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Reference: the a-words of a layer are all addresses with bit L clear, in
    // ascending order; b is its partner and the twiddle follows the group index.
    task automatic push_layer(input int L);
        for (int a = 0; a < (1 << AW); a++) begin
            if (((a >> L) & 1) == 0) begin
                pair_t e;
                e.a = a;
                e.b = a + (1 << L);
                e.t = ((1 << (AW - 1)) >> L) + (a >> (L + 1));
                rq.push_back(e);
                wq.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            bit exp_busy;
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(cyc == done_cyc));
            chk("err", int'(err), int'(cyc == err_cyc));
            chk("fpu_en", int'(fpu_en), int'(exp_busy && !hold));
            if (exp_busy) chk("fpu_mode", int'(fpu_mode), cur_mode);
            if (hold && exp_busy) begin
                chk("hold_rd_en", int'(rd_en), 0);
                chk("hold_wr_en", int'(wr_en), 0);
            end
            if (rd_en) begin
                if (rq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    pair_t e;
                    e = rq.pop_front();
                    chk("rd_addr_a", int'(rd_addr_a), e.a);
                    chk("rd_addr_b", int'(rd_addr_b), e.b);
                    chk("tw_addr", int'(tw_addr), e.t);
                end
            end
            if (wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    pair_t e;
                    e = wq.pop_front();
                    chk("wr_addr_a", int'(wr_addr_a), e.a);
                    chk("wr_addr_b", int'(wr_addr_b), e.b);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr_a"}, int'(rd_addr_a), 0);
        chk({tag, "_rd_addr_b"}, int'(rd_addr_b), 0);
        chk({tag, "_tw_addr"}, int'(tw_addr), 0);
        chk({tag, "_fpu_en"}, int'(fpu_en), 0);
        chk({tag, "_fpu_mode"}, int'(fpu_mode), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr_a"}, int'(wr_addr_a), 0);
        chk({tag, "_wr_addr_b"}, int'(wr_addr_b), 0);
    endtask

    // One layer run starting in the current cycle; hold windows are relative to start.
    task automatic run(input int L, input int md, input int h1s, input int h1l,
                       input int h2s, input int h2l, input bit second, input bit do_rst);
        int base, last;
        base     = cyc;
        cur_mode = md;
        push_layer(L);
        busy_lo  = base + 1;
        busy_hi  = base + 90 + h1l + h2l;
        done_cyc = busy_hi;
        err_cyc  = -1;
        if (do_rst) begin
            busy_hi  = base + 30;
            done_cyc = -1;
        end
        last = do_rst ? 31 : 92 + h1l + h2l;
        for (int rel = 0; rel <= last; rel++) begin
            start  = (rel == 0) || (second && rel == 40);
            layer  = (rel == 0) ? 4'(L) : 4'd7;
            mode_i = (rel == 0) ? MW'(md) : MW'(~md);
            hold   = (rel >= h1s && rel < h1s + h1l) || (rel >= h2s && rel < h2s + h2l);
            rst    = do_rst && rel == 30;
            if (do_rst && rel == 31) begin
                rq.delete();
                wq.delete();
                @(negedge clk);
                check_all_zero("midrst");
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        rst   = 1'b0;
        if (!do_rst) begin
            chk("rd_left", rq.size(), 0);
            chk("wr_left", wq.size(), 0);
        end
    endtask

    task automatic bad_start(input int L);
        busy_lo  = -1;
        busy_hi  = -2;
        done_cyc = -1;
        err_cyc  = cyc + 1;
        start    = 1'b1;
        layer    = 4'(L);
        mode_i   = MW'($urandom_range(7));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; layer = '0; mode_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        checking = 1'b1;

        run(0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        run(6, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        run(3, 7, 0, 0, 0, 0, 1'b0, 1'b0);
        run(0, 5, 10, 5, 75, 3, 1'b0, 1'b0);
        bad_start(7);
        run(0, 2, 0, 0, 0, 0, 1'b1, 1'b0);
        run(0, 3, 0, 0, 0, 0, 1'b0, 1'b1);
        run(0, 4, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(6), $urandom_range(7),
                $urandom_range(59, 2), $urandom_range(6),
                $urandom_range(76, 72), $urandom_range(4), 1'b0, 1'b0);
            bad_start($urandom_range(15, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
